mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle control unit that sequences instruction execution for the MIPS-subset datapath and drives the 3-bit operation code, operand selects and the write enables around the shared ALU. It decodes opcode/funct from the instruction register and the ALU `zero` flag, and steps through fetch, decode, execute, memory and write-back states. It stalls on a single-bit memory ready handshake. It sits between the instruction register and every datapath mux and enable.

## Interface
Parameters:
- none; all encodings are fixed constants in `ctrl_pkg`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `opcode`  in  6  instr[31:26] from the IR.
- `funct`  in  6  instr[5:0] from the IR.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `alu_op`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll.
- `alu_src_a`  out  2  0 = PC, 1 = A reg, 2 = B reg.
- `alu_src_b`  out  3  0 = B reg, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2, 4 = zero-ext shamt.
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut reg, 2 = jump target.
- `pc_en`, `ir_write`, `iord`, `mem_read`, `mem_write`, `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each.
- `illegal_instr`  out  1  one-cycle pulse when an unsupported opcode/funct is decoded.

## Operation
Supported instructions:
- R-type (opcode 000000), by funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000.
- I-type and jumps, by opcode: lw 100011, sw 101011, addi 001000, slti 001010, beq 000100, j 000010.

The unit is a Moore FSM. Defaults are 0 and alu_op = add. Each state drives only the signals listed:
- FETCH: mem_read=1, iord=0, src_a=0, src_b=1, pc_src=0.
  - While mem_ready=1: ir_write=1 and pc_en=1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: src_a=0, src_b=3, alu_op=add (branch target is latched into ALUOut).
  - Dispatch on opcode to MEM_ADDR (lw/sw), EXEC_R, EXEC_I (addi/slti), BRANCH or JUMP.
  - Unknown opcode or R-type funct: illegal_instr=1, go to FETCH.
- EXEC_R: alu_op taken from funct.
  - sll: src_a=2, src_b=4.
  - All other R-type: src_a=1, src_b=0.
  - Next state ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
- EXEC_I: src_a=1, src_b=2, alu_op = add (addi) or slt (slti); next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=add; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, iord=1; hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready, then go to FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=sub, pc_src=1, pc_en=zero; next FETCH.
- JUMP: pc_src=2, pc_en=1; next FETCH.

## Timing
- Reset:
  - When rst_n=0 at a rising edge, the next state is FETCH.
  - While rst_n=0, every output is forced to 0, including alu_op=000 and illegal_instr=0.
  - Reset mid-instruction abandons it. No memory strobe may remain asserted in the cycle after the reset edge.
- Latency with zero-wait memory (mem_ready held 1), counting FETCH through the last state:
  - lw: 5 cycles.
  - sw, R-type, addi, slti: 4 cycles.
  - beq, j: 3 cycles.
- Wait states: each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Outputs stay stable throughout the wait.
- Holding enables:
  - ir_write and pc_en in FETCH are asserted only in the cycle where mem_ready=1.
  - They are never asserted during wait cycles.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- beq: pc_en equals `zero` in the same BRANCH cycle (combinational path from zero to pc_en).
- Outputs other than the FETCH enables and the BRANCH pc_en are pure functions of the registered state.

## Structure
- `ctrl_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - alu_op encodings, shared with the ALU;
  - the src_a, src_b and pc_src select encodings.
- Sub-module `alu_decoder` is combinational and maps (opcode, funct) to alu_op plus an R-type legal flag. `mc_controller` instantiates it for the EXEC_R and EXEC_I states and for illegal detection.
- `mc_controller` contains the state register, the next-state logic and the output decode.

## Test plan
- Reset held low for 2 cycles, then released, with opcode=100011 and mem_ready=1:
  - all outputs are 0 during reset;
  - the first cycle is FETCH with mem_read=1, src_b=1, pc_en=1, ir_write=1.
- R-type sub (funct 100010), mem_ready=1:
  - sequence FETCH→DECODE→EXEC_R (alu_op=001, src_a=1, src_b=0)→ALU_WB (reg_write=1, reg_dst=1);
  - 4 cycles total.
- sll (funct 000000) gives EXEC_R alu_op=110, src_a=2, src_b=4. slti gives EXEC_I alu_op=101, src_b=2.
- lw with mem_ready low for 3 cycles in MEM_RD:
  - mem_read=1 and iord=1 stay stable for those cycles;
  - MEM_WB follows with mem_to_reg=1;
  - 8 cycles total.
- beq with zero=1 gives pc_en=1 and pc_src=1 in BRANCH. With zero=0, pc_en=0. Both take 3 cycles.
- Edge cases:
  - opcode 111111 gives illegal_instr=1 for exactly the DECODE cycle, then FETCH.
  - rst_n driven low in MEM_WR gives mem_write=0 on the next cycle, followed by FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit and its ALU.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode/funct values, alu_op codes, mux select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_ALU_WB,
    S_EXEC_I,
    S_I_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } state_t;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  // ALU operation codes, shared with the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;
  localparam logic [1:0] SRCA_B  = 2'd2;

  // ALU operand B select
  localparam logic [2:0] SRCB_B      = 3'd0;
  localparam logic [2:0] SRCB_FOUR   = 3'd1;
  localparam logic [2:0] SRCB_IMM    = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH = 3'd3;
  localparam logic [2:0] SRCB_SHAMT  = 3'd4;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Maps (opcode, funct) to the ALU operation and flags legal R-type functs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: opcode/funct in from the IR; alu_op out to the ALU; r_legal high for supported R-type funct.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       r_legal
);

  always_comb begin
    alu_op  = ALU_ADD;
    r_legal = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  begin alu_op = ALU_ADD; r_legal = 1'b1; end
        FN_SUB:  begin alu_op = ALU_SUB; r_legal = 1'b1; end
        FN_AND:  begin alu_op = ALU_AND; r_legal = 1'b1; end
        FN_OR:   begin alu_op = ALU_OR;  r_legal = 1'b1; end
        FN_SLT:  begin alu_op = ALU_SLT; r_legal = 1'b1; end
        FN_SLL:  begin alu_op = ALU_SLL; r_legal = 1'b1; end
        default: begin alu_op = ALU_ADD; r_legal = 1'b0; end
      endcase
    end else if (opcode == OP_SLTI) begin
      alu_op = ALU_SLT;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle Moore control FSM for the MIPS-subset datapath around one shared ALU.
// Latency: lw 5, sw/R/addi/slti 4, beq/j 3 cycles with zero-wait memory.
// Backpressure: FETCH, MEM_RD, MEM_WR hold with stable outputs while mem_ready is low.
// Ports: clk, rst_n (sync, active-low); opcode/funct from IR; zero from ALU; mem_ready from memory;
//        alu_op, alu_src_a/b, pc_src selects and pc_en/ir_write/iord/mem_read/mem_write/
//        reg_write/reg_dst/mem_to_reg enables; illegal_instr pulse in DECODE.
module mc_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_instr
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] dec_alu_op;
  logic       dec_r_legal;

  alu_decoder u_alu_decoder (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_alu_op),
    .r_legal (dec_r_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    alu_op        = ALU_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    pc_en         = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC capture only on the cycle memory delivers the word
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE: begin
            if (dec_r_legal) begin
              state_nxt = S_EXEC_R;
            end else begin
              illegal_instr = 1'b1;
              state_nxt     = S_FETCH;
            end
          end
          OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: state_nxt = S_EXEC_I;
          OP_BEQ:           state_nxt = S_BRANCH;
          OP_J:             state_nxt = S_JUMP;
          default: begin
            illegal_instr = 1'b1;
            state_nxt     = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_op = dec_alu_op;
        // sll shifts rt (B reg) by shamt rather than combining A and B
        if (dec_alu_op == ALU_SLL) begin
          alu_src_a = SRCA_B;
          alu_src_b = SRCB_SHAMT;
        end else begin
          alu_src_a = SRCA_A;
          alu_src_b = SRCB_B;
        end
        state_nxt = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = dec_alu_op;
        state_nxt = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        state_nxt = S_FETCH;
      end

      S_JUMP: begin
        pc_src    = PCSRC_JUMP;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end

      default: state_nxt = S_FETCH;
    endcase

    // Outputs are held quiet for the whole reset window, independent of state
    if (!rst_n) begin
      alu_op        = 3'b000;
      alu_src_a     = 2'd0;
      alu_src_b     = 3'd0;
      pc_src        = 2'd0;
      pc_en         = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: per-cycle output vectors checked against hand-written values.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: mem_ready wait cycles exercised in FETCH, MEM_RD and MEM_WR.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal_instr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .pc_en         (pc_en),
    .ir_write      (ir_write),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal_instr (illegal_instr)
  );

  // Output bundle: {alu_op, src_a, src_b, pc_src, pc_en, ir_write, iord,
  //                 mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal}
  logic [18:0] ov;
  assign ov = {alu_op, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, iord,
               mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal_instr};

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_BAD = 6'b000001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [18:0] pk(input logic [2:0] a, input logic [1:0] sa,
                                     input logic [2:0] sb, input logic [1:0] ps,
                                     input logic pe, input logic irw, input logic io,
                                     input logic mr, input logic mw, input logic rw,
                                     input logic rd, input logic m2r, input logic ill);
    return {a, sa, sb, ps, pe, irw, io, mr, mw, rw, rd, m2r, ill};
  endfunction

  // One clock cycle: drive inputs on the falling edge, check outputs shortly after
  task automatic cyc(input string tag, input logic rs, input logic [5:0] op,
                     input logic [5:0] fn, input logic mr, input logic z,
                     input logic [18:0] e);
    @(negedge clk);
    rst_n     = rs;
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    zero      = z;
    #1;
    chk(tag, {13'd0, ov}, {13'd0, e});
  endtask

  logic [18:0] e_z, e_f, e_fw, e_d, e_di, e_sub, e_sll, e_or, e_awb, e_addi, e_slti;
  logic [18:0] e_iwb, e_ma, e_mrd, e_mwb, e_mwr, e_br1, e_br0, e_jmp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    e_z    = '0;
    e_f    = pk(3'd0, 2'd0, 3'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_fw   = pk(3'd0, 2'd0, 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_d    = pk(3'd0, 2'd0, 3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_di   = pk(3'd0, 2'd0, 3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e_sub  = pk(3'd1, 2'd1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_sll  = pk(3'd6, 2'd2, 3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_or   = pk(3'd3, 2'd1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_awb  = pk(3'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_addi = pk(3'd0, 2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_slti = pk(3'd5, 2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_iwb  = pk(3'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_ma   = pk(3'd0, 2'd1, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_mrd  = pk(3'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_mwb  = pk(3'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    e_mwr  = pk(3'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_br1  = pk(3'd1, 2'd1, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_br0  = pk(3'd1, 2'd1, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_jmp  = pk(3'd0, 2'd0, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; opcode = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // Reset held for two cycles: everything quiet
    cyc("rst0", 1'b0, LW, 6'd0, 1'b1, 1'b0, e_z);
    cyc("rst1", 1'b0, LW, 6'd0, 1'b1, 1'b0, e_z);

    // lw, zero-wait: 5 cycles
    cyc("lw_fetch",  1'b1, LW, 6'd0, 1'b1, 1'b0, e_f);
    cyc("lw_dec",    1'b1, LW, 6'd0, 1'b1, 1'b0, e_d);
    cyc("lw_maddr",  1'b1, LW, 6'd0, 1'b1, 1'b0, e_ma);
    cyc("lw_mrd",    1'b1, LW, 6'd0, 1'b1, 1'b0, e_mrd);
    cyc("lw_mwb",    1'b1, LW, 6'd0, 1'b1, 1'b0, e_mwb);

    // R-type sub: 4 cycles
    cyc("sub_fetch", 1'b1, RT, F_SUB, 1'b1, 1'b0, e_f);
    cyc("sub_dec",   1'b1, RT, F_SUB, 1'b1, 1'b0, e_d);
    cyc("sub_exec",  1'b1, RT, F_SUB, 1'b1, 1'b0, e_sub);
    cyc("sub_wb",    1'b1, RT, F_SUB, 1'b1, 1'b0, e_awb);

    // sll, with mem_ready low in DECODE (must be ignored)
    cyc("sll_fetch", 1'b1, RT, F_SLL, 1'b1, 1'b0, e_f);
    cyc("sll_dec",   1'b1, RT, F_SLL, 1'b0, 1'b0, e_d);
    cyc("sll_exec",  1'b1, RT, F_SLL, 1'b0, 1'b0, e_sll);
    cyc("sll_wb",    1'b1, RT, F_SLL, 1'b0, 1'b0, e_awb);

    // or
    cyc("or_fetch",  1'b1, RT, F_OR, 1'b1, 1'b0, e_f);
    cyc("or_dec",    1'b1, RT, F_OR, 1'b1, 1'b0, e_d);
    cyc("or_exec",   1'b1, RT, F_OR, 1'b1, 1'b0, e_or);
    cyc("or_wb",     1'b1, RT, F_OR, 1'b1, 1'b0, e_awb);

    // slti
    cyc("slti_fetch", 1'b1, SLTI, 6'd0, 1'b1, 1'b0, e_f);
    cyc("slti_dec",   1'b1, SLTI, 6'd0, 1'b1, 1'b0, e_d);
    cyc("slti_exec",  1'b1, SLTI, 6'd0, 1'b1, 1'b0, e_slti);
    cyc("slti_wb",    1'b1, SLTI, 6'd0, 1'b1, 1'b0, e_iwb);

    // addi with one FETCH wait cycle: no ir_write/pc_en while waiting
    cyc("addi_fwait", 1'b1, ADDI, 6'd0, 1'b0, 1'b0, e_fw);
    cyc("addi_fetch", 1'b1, ADDI, 6'd0, 1'b1, 1'b0, e_f);
    cyc("addi_dec",   1'b1, ADDI, 6'd0, 1'b1, 1'b0, e_d);
    cyc("addi_exec",  1'b1, ADDI, 6'd0, 1'b1, 1'b0, e_addi);
    cyc("addi_wb",    1'b1, ADDI, 6'd0, 1'b1, 1'b0, e_iwb);

    // lw with three MEM_RD wait cycles: 8 cycles
    cyc("lww_fetch", 1'b1, LW, 6'd0, 1'b1, 1'b0, e_f);
    cyc("lww_dec",   1'b1, LW, 6'd0, 1'b1, 1'b0, e_d);
    cyc("lww_maddr", 1'b1, LW, 6'd0, 1'b1, 1'b0, e_ma);
    for (int i = 0; i < 3; i++)
      cyc("lww_mrd_wait", 1'b1, LW, 6'd0, 1'b0, 1'b0, e_mrd);
    cyc("lww_mrd",   1'b1, LW, 6'd0, 1'b1, 1'b0, e_mrd);
    cyc("lww_mwb",   1'b1, LW, 6'd0, 1'b1, 1'b0, e_mwb);

    // beq taken and not taken: 3 cycles each
    cyc("beq1_fetch", 1'b1, BEQ, 6'd0, 1'b1, 1'b0, e_f);
    cyc("beq1_dec",   1'b1, BEQ, 6'd0, 1'b1, 1'b0, e_d);
    cyc("beq1_br",    1'b1, BEQ, 6'd0, 1'b1, 1'b1, e_br1);
    cyc("beq0_fetch", 1'b1, BEQ, 6'd0, 1'b1, 1'b1, e_f);
    cyc("beq0_dec",   1'b1, BEQ, 6'd0, 1'b1, 1'b1, e_d);
    cyc("beq0_br",    1'b1, BEQ, 6'd0, 1'b1, 1'b0, e_br0);

    // j: 3 cycles
    cyc("j_fetch", 1'b1, JMP, 6'd0, 1'b1, 1'b0, e_f);
    cyc("j_dec",   1'b1, JMP, 6'd0, 1'b1, 1'b0, e_d);
    cyc("j_jump",  1'b1, JMP, 6'd0, 1'b1, 1'b0, e_jmp);

    // Illegal opcode, then illegal R-type funct: one-cycle pulse, back to FETCH
    cyc("ill_fetch",  1'b1, BAD, 6'd0, 1'b1, 1'b0, e_f);
    cyc("ill_dec",    1'b1, BAD, 6'd0, 1'b1, 1'b0, e_di);
    cyc("illf_fetch", 1'b1, RT, F_BAD, 1'b1, 1'b0, e_f);
    cyc("illf_dec",   1'b1, RT, F_BAD, 1'b1, 1'b0, e_di);

    // sw, zero-wait: 4 cycles
    cyc("sw_fetch", 1'b1, SW, 6'd0, 1'b1, 1'b0, e_f);
    cyc("sw_dec",   1'b1, SW, 6'd0, 1'b1, 1'b0, e_d);
    cyc("sw_maddr", 1'b1, SW, 6'd0, 1'b1, 1'b0, e_ma);
    cyc("sw_mwr",   1'b1, SW, 6'd0, 1'b1, 1'b0, e_mwr);

    // sw stalled in MEM_WR, then reset abandons it
    cyc("swr_fetch", 1'b1, SW, 6'd0, 1'b1, 1'b0, e_f);
    cyc("swr_dec",   1'b1, SW, 6'd0, 1'b1, 1'b0, e_d);
    cyc("swr_maddr", 1'b1, SW, 6'd0, 1'b1, 1'b0, e_ma);
    cyc("swr_wait0", 1'b1, SW, 6'd0, 1'b0, 1'b0, e_mwr);
    cyc("swr_wait1", 1'b1, SW, 6'd0, 1'b0, 1'b0, e_mwr);
    cyc("swr_rst",   1'b0, SW, 6'd0, 1'b0, 1'b0, e_z);
    chk("swr_rst_mem_write", {31'd0, mem_write}, 32'd0);
    cyc("swr_after", 1'b1, SW, 6'd0, 1'b1, 1'b0, e_f);
    cyc("swr_dec2",  1'b1, SW, 6'd0, 1'b1, 1'b0, e_d);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
